// File: rtl/mac4b_acc.sv
// Multiply-accumulate stage: a 4x4 multiplier feeds an accumulator that sums
// LEN products per frame and hands each frame sum downstream over valid/ready.

module mul4b (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] p
);
  assign p = a * b;
endmodule

module mac4b_acc #(
  parameter int LEN  = 4,
  parameter int ACCW = 10,
  parameter int CNTW = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      ina,
  input  logic [3:0]      inb,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [ACCW-1:0] sum,
  output logic            ovf
);

  typedef enum logic {ACC, DONE} state_t;

  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(LEN - 1);

  state_t          state, next_state;
  logic [7:0]      prod;
  logic [ACCW:0]   prod_ext;
  logic [ACCW:0]   add;
  logic [ACCW-1:0] acc;
  logic [CNTW-1:0] cnt;
  logic            ovf_r;
  logic            transfer;
  logic            last;

  mul4b u_mul (
    .a (ina),
    .b (inb),
    .p (prod)
  );

  // The extra top bit of the sum is the carry-out that feeds the sticky overflow.
  assign prod_ext = {{(ACCW + 1 - 8){1'b0}}, prod};
  assign add      = {1'b0, acc} + prod_ext;
  assign transfer = in_valid && in_ready;
  assign last     = (cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) state <= ACC;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      ACC: begin
        in_ready = 1'b1;
        if (in_valid && last) next_state = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) next_state = ACC;
      end
      default: next_state = ACC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc   <= '0;
      cnt   <= '0;
      ovf_r <= 1'b0;
      sum   <= '0;
      ovf   <= 1'b0;
    end else if (transfer) begin
      if (last) begin
        sum   <= add[ACCW-1:0];
        ovf   <= ovf_r | add[ACCW];
        acc   <= '0;
        cnt   <= '0;
        ovf_r <= 1'b0;
      end else begin
        acc   <= add[ACCW-1:0];
        cnt   <= cnt + 1'b1;
        ovf_r <= ovf_r | add[ACCW];
      end
    end
  end

endmodule
